// File: rtl/conf_spi_regfile.sv
// SPI configuration receiver: oversamples the ARM SPI link, decodes fixed-length frames
// into shadow registers and transfers them to the active outputs on glitch-safe cycles.
module conf_spi_regfile #(
    parameter int DW         = 8,
    parameter int NREGS      = 4,
    parameter int FRAME_BITS = 16
) (
    input  logic                ck_1356meg,
    input  logic                nrst,
    input  logic                spck,
    input  logic                ncs,
    input  logic                mosi,
    output logic                miso,
    input  logic                commit_ok,
    output logic [NREGS*DW-1:0] conf_regs,
    output logic                conf_update,
    output logic                frame_err
);

    localparam int CW = $clog2(FRAME_BITS + 2);
    localparam int PW = (NREGS > 1) ? $clog2(NREGS) : 1;

    logic [2:0]            spck_p;
    logic [2:0]            ncs_p;
    logic [1:0]            mosi_p;
    logic                  spck_rise, spck_fall, ncs_rise, ncs_fall, ncs_s, mosi_s;

    logic [FRAME_BITS-1:0] rx_shift;
    logic [FRAME_BITS-1:0] tx_shift;
    logic [CW-1:0]         bit_cnt;
    logic                  frame_active;

    logic [DW-1:0]         shadow [NREGS];
    logic [DW-1:0]         active [NREGS];
    logic [NREGS-1:0]      pending;
    logic [PW-1:0]         rd_ptr;

    logic [3:0]            opcode, index;
    logic [DW-1:0]         wr_data;
    logic                  len_ok, idx_ok, do_write, do_read, do_err, do_commit;
    logic [NREGS-1:0]      wr_mask;

    // ncs synchroniser resets low so a frame already in flight at reset release never
    // produces a falling edge; frame_active then keeps its trailing rise from decoding.
    always_ff @(posedge ck_1356meg or negedge nrst) begin
        if (!nrst) begin
            spck_p <= '0;
            ncs_p  <= '0;
            mosi_p <= '0;
        end else begin
            spck_p <= {spck_p[1:0], spck};
            ncs_p  <= {ncs_p[1:0], ncs};
            mosi_p <= {mosi_p[0], mosi};
        end
    end

    assign ncs_s     = ncs_p[1];
    assign mosi_s    = mosi_p[1];
    assign spck_rise = spck_p[1] & ~spck_p[2];
    assign spck_fall = ~spck_p[1] & spck_p[2];
    assign ncs_rise  = ncs_p[1] & ~ncs_p[2];
    assign ncs_fall  = ~ncs_p[1] & ncs_p[2];

    assign opcode  = rx_shift[FRAME_BITS-1 -: 4];
    assign index   = rx_shift[FRAME_BITS-5 -: 4];
    assign wr_data = rx_shift[DW-1:0];

    always_comb begin
        len_ok   = (bit_cnt == CW'(FRAME_BITS));
        idx_ok   = ({28'd0, index} < 32'(NREGS));
        do_write = 1'b0;
        do_read  = 1'b0;
        do_err   = 1'b0;
        wr_mask  = '0;
        if (ncs_rise && frame_active) begin
            if (len_ok && idx_ok && opcode == 4'b0001) begin
                do_write = 1'b1;
                wr_mask  = NREGS'(1) << index;
            end else if (len_ok && idx_ok && opcode == 4'b1000) begin
                do_read = 1'b1;
            end else begin
                do_err = 1'b1;
            end
        end
        do_commit = commit_ok && (pending != '0);
    end

    always_ff @(posedge ck_1356meg or negedge nrst) begin
        if (!nrst) begin
            rx_shift     <= '0;
            bit_cnt      <= '0;
            frame_active <= 1'b0;
        end else begin
            if (spck_rise && !ncs_s)
                rx_shift <= {rx_shift[FRAME_BITS-2:0], mosi_s};
            if (ncs_fall)
                bit_cnt <= '0;
            else if (spck_rise && !ncs_s && bit_cnt != CW'(FRAME_BITS + 1))
                bit_cnt <= bit_cnt + 1'b1;
            if (ncs_fall)
                frame_active <= 1'b1;
            else if (ncs_rise)
                frame_active <= 1'b0;
        end
    end

    // A write decoded in a commit cycle lands in pending only, never straight in active.
    always_ff @(posedge ck_1356meg or negedge nrst) begin
        if (!nrst) begin
            for (int i = 0; i < NREGS; i++) begin
                shadow[i] <= '0;
                active[i] <= '0;
            end
            pending     <= '0;
            rd_ptr      <= '0;
            conf_update <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if (wr_mask[i])
                    shadow[i] <= wr_data;
                if (do_commit && pending[i])
                    active[i] <= shadow[i];
            end
            pending     <= (do_commit ? '0 : pending) | wr_mask;
            if (do_read)
                rd_ptr <= index[PW-1:0];
            conf_update <= do_commit;
            frame_err   <= do_err;
        end
    end

    always_ff @(posedge ck_1356meg or negedge nrst) begin
        if (!nrst)
            tx_shift <= '0;
        else if (ncs_fall)
            tx_shift <= {active[rd_ptr], {(FRAME_BITS-DW){1'b0}}};
        else if (spck_fall && !ncs_s)
            tx_shift <= {tx_shift[FRAME_BITS-2:0], 1'b0};
    end

    assign miso = ~ncs_s & tx_shift[FRAME_BITS-1];

    always_comb begin
        conf_regs = '0;
        for (int i = 0; i < NREGS; i++)
            conf_regs[i*DW +: DW] = active[i];
    end

endmodule
